// File: rtl/cva6_ptw_sv32.sv
// Sv32 hardware page-table walker feeding cva6_tlb_sv32.update_i.
// Walks one TLB miss at a time: reads the level-1 PTE and, for a pointer
// PTE, the level-0 PTE, with at most one memory read outstanding.
// Produces a one-cycle 63-bit update word
// {valid, is_4M, vpn[19:0], asid[8:0], pte[31:0]} or a one-cycle fault pulse.
// Optional feature macro: PTW_ACCESS_CHECK_EN. When it is defined, a leaf PTE
// with A=0 faults. When it is undefined, the A bit is passed to the TLB as-is.
module cva6_ptw_sv32 #(
  parameter int ASID_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [21:0]           satp_ppn_i,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [31:0]           miss_vaddr_i,
  input  logic [ASID_WIDTH-1:0] miss_asid_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [33:0]           mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [31:0]           mem_rsp_data_i,
  output logic [62:0]           update_o,
  output logic                  fault_o,
  output logic [31:0]           fault_vaddr_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_L1_REQ  = 3'd1,
    S_L1_WAIT = 3'd2,
    S_L0_REQ  = 3'd3,
    S_L0_WAIT = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  state_t                state_r;
  logic [31:0]           vaddr_r;
  logic [ASID_WIDTH-1:0] asid_r;
  logic                  req_valid_r;
  logic [33:0]           req_addr_r;
  logic [62:0]           update_r;
  logic                  fault_r;
  logic [31:0]           fault_vaddr_r;
  logic                  busy_r;

  logic [8:0]            asid_ext_s;
  logic                  pte_invalid_s;
  logic                  pte_leaf_s;
  logic                  misaligned_s;
  logic                  access_fault_s;
  logic                  l1_fault_s;
  logic                  l0_fault_s;
  logic [62:0]           update_l1_s;
  logic [62:0]           update_l0_s;

  // A PTE is malformed when it is not valid or is write-only (W without R).
  function automatic logic pte_is_invalid(input logic [31:0] pte);
    return (~pte[0]) | ((~pte[1]) & pte[2]);
  endfunction

  // A PTE is a leaf when it grants read or execute permission.
  function automatic logic pte_is_leaf(input logic [31:0] pte);
    return pte[1] | pte[3];
  endfunction

  assign miss_ready_o    = (state_r == S_IDLE) & ~flush_i;
  assign mem_req_valid_o = req_valid_r;
  assign mem_req_addr_o  = req_addr_r;
  assign update_o        = update_r;
  assign fault_o         = fault_r;
  assign fault_vaddr_o   = fault_vaddr_r;
  assign busy_o          = busy_r;

  // Decode the PTE currently on the response bus and pre-build the update words.
  always_comb begin
    asid_ext_s                   = 9'd0;
    asid_ext_s[ASID_WIDTH-1:0]   = asid_r;
    pte_invalid_s                = pte_is_invalid(mem_rsp_data_i);
    pte_leaf_s                   = pte_is_leaf(mem_rsp_data_i);
    misaligned_s                 = (mem_rsp_data_i[19:10] != 10'd0);
`ifdef PTW_ACCESS_CHECK_EN
    access_fault_s               = ~mem_rsp_data_i[6];
`else
    access_fault_s               = 1'b0;
`endif
    l1_fault_s  = pte_invalid_s | (pte_leaf_s & (misaligned_s | access_fault_s));
    l0_fault_s  = pte_invalid_s | ~pte_leaf_s | access_fault_s;
    update_l1_s = {1'b1, 1'b1, vaddr_r[31:12], asid_ext_s, mem_rsp_data_i};
    update_l0_s = {1'b1, 1'b0, vaddr_r[31:12], asid_ext_s, mem_rsp_data_i};
  end

  // Walk FSM: sequences the PTE reads and registers every output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= S_IDLE;
      vaddr_r       <= 32'd0;
      asid_r        <= '0;
      req_valid_r   <= 1'b0;
      req_addr_r    <= 34'd0;
      update_r      <= 63'd0;
      fault_r       <= 1'b0;
      fault_vaddr_r <= 32'd0;
      busy_r        <= 1'b0;
    end else begin
      update_r <= 63'd0;
      fault_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (miss_valid_i && !flush_i) begin
            vaddr_r     <= miss_vaddr_i;
            asid_r      <= miss_asid_i;
            req_addr_r  <= {satp_ppn_i, miss_vaddr_i[31:22], 2'b00};
            req_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= S_L1_REQ;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_L1_REQ, S_L0_REQ: begin
          if (flush_i) begin
            // A request accepted in the flush cycle still returns data.
            req_valid_r <= 1'b0;
            if (mem_req_ready_i) begin
              state_r <= S_DRAIN;
            end else begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end
          end else if (mem_req_ready_i) begin
            req_valid_r <= 1'b0;
            state_r     <= (state_r == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
          end else begin
            state_r <= state_r;
          end
        end
        S_L1_WAIT: begin
          if (flush_i) begin
            // A response in the flush cycle is simply discarded.
            if (mem_rsp_valid_i) begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= S_DRAIN;
            end
          end else if (mem_rsp_valid_i) begin
            if (l1_fault_s) begin
              fault_r       <= 1'b1;
              fault_vaddr_r <= vaddr_r;
              state_r       <= S_IDLE;
              busy_r        <= 1'b0;
            end else if (pte_leaf_s) begin
              update_r <= update_l1_s;
              state_r  <= S_IDLE;
              busy_r   <= 1'b0;
            end else begin
              req_addr_r  <= {mem_rsp_data_i[31:10], vaddr_r[21:12], 2'b00};
              req_valid_r <= 1'b1;
              state_r     <= S_L0_REQ;
            end
          end else begin
            state_r <= S_L1_WAIT;
          end
        end
        S_L0_WAIT: begin
          if (flush_i) begin
            if (mem_rsp_valid_i) begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= S_DRAIN;
            end
          end else if (mem_rsp_valid_i) begin
            if (l0_fault_s) begin
              fault_r       <= 1'b1;
              fault_vaddr_r <= vaddr_r;
            end else begin
              update_r <= update_l0_s;
            end
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= S_L0_WAIT;
          end
        end
        S_DRAIN: begin
          if (mem_rsp_valid_i) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= S_DRAIN;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          req_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cva6_ptw_sv32.sv
// Self-checking bench for cva6_ptw_sv32: a reactive PTE memory model,
// a scoreboard of expected updates/faults and a queue of expected PTE addresses.
module tb_cva6_ptw_sv32;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [21:0] satp;
  logic        miss_valid;
  logic        miss_ready;
  logic [31:0] miss_vaddr;
  logic [0:0]  miss_asid;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [33:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [62:0] update;
  logic        fault;
  logic [31:0] fault_vaddr;
  logic        busy;

  typedef struct {
    logic        is_fault;
    logic [62:0] upd;
    logic [31:0] fva;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  logic [33:0] expq[$];
  logic [31:0] mem [logic [33:0]];

  int          total;
  int          bad;
  int          cyc;
  int          accept_cyc;
  int          pend_cnt;
  logic [31:0] pend_data;
  int          extra_delay;
  int          stall;

  cva6_ptw_sv32 #(.ASID_WIDTH(1)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .satp_ppn_i      (satp),
    .miss_valid_i    (miss_valid),
    .miss_ready_o    (miss_ready),
    .miss_vaddr_i    (miss_vaddr),
    .miss_asid_i     (miss_asid),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_addr_o  (mem_req_addr),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_data_i  (mem_rsp_data),
    .update_o        (update),
    .fault_o         (fault),
    .fault_vaddr_o   (fault_vaddr),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: sample outputs at the falling edge, then drive memory-side inputs.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (update[62] || fault) begin
      check_eq("upd_fault_excl", {63'd0, update[62] & fault}, 64'd0);
      if (sbq.size() == 0) begin
        check_eq("spurious_result", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        check_eq("result_kind", {63'd0, fault}, {63'd0, e.is_fault});
        if (e.is_fault) begin
          check_eq("fault_vaddr", {32'd0, fault_vaddr}, {32'd0, e.fva});
          check_eq("fault_upd_zero", {1'b0, update}, 64'd0);
        end else begin
          check_eq("update_word", {1'b0, update}, {1'b0, e.upd});
        end
        if (e.lat != 0) check_eq("latency", 64'(cyc - accept_cyc), 64'(e.lat));
      end
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'hDEAD_BEEF;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = pend_data;
      end
    end
    mem_req_ready = (stall == 0);
    if (stall > 0) stall--;
    if (mem_req_valid && mem_req_ready) begin
      if (expq.size() == 0) check_eq("unexpected_req", 64'd1, 64'd0);
      else check_eq("req_addr", {30'd0, mem_req_addr}, {30'd0, expq.pop_front()});
      pend_cnt    = 1 + extra_delay;
      extra_delay = 0;
      pend_data   = mem.exists(mem_req_addr) ? mem[mem_req_addr] : 32'h0000_0000;
    end else if (mem_req_valid && expq.size() != 0) begin
      check_eq("addr_stable", {30'd0, mem_req_addr}, {30'd0, expq[0]});
    end
  endtask

  task automatic issue(input logic [31:0] va, input logic asid);
    for (int i = 0; i < 20 && !miss_ready; i++) tick();
    check_eq("miss_ready_idle", {63'd0, miss_ready}, 64'd1);
    miss_valid = 1'b1;
    miss_vaddr = va;
    miss_asid  = asid;
    accept_cyc = cyc;
    tick();
    miss_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (sbq.size() != 0 || busy || pend_cnt != 0); i++) tick();
    check_eq("sb_empty", 64'(sbq.size()), 64'd0);
    check_eq("reqq_empty", 64'(expq.size()), 64'd0);
  endtask

  task automatic push_upd(input logic is4m, input logic [31:0] va, input logic asid,
                          input logic [31:0] pte, input int lat);
    exp_t e;
    e.is_fault = 1'b0;
    e.upd      = {1'b1, is4m, va[31:12], 8'd0, asid, pte};
    e.fva      = 32'd0;
    e.lat      = lat;
    sbq.push_back(e);
  endtask

  task automatic push_fault(input logic [31:0] va, input int lat);
    exp_t e;
    e.is_fault = 1'b1;
    e.upd      = 63'd0;
    e.fva      = va;
    e.lat      = lat;
    sbq.push_back(e);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; accept_cyc = 0;
    pend_cnt = 0; pend_data = 32'd0; extra_delay = 0; stall = 0;
    rst = 1'b1; flush = 1'b0; satp = 22'h00010;
    miss_valid = 1'b0; miss_vaddr = 32'd0; miss_asid = 1'b0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    check_eq("rst_update", {1'b0, update}, 64'd0);
    check_eq("rst_fault", {63'd0, fault}, 64'd0);
    check_eq("rst_fault_vaddr", {32'd0, fault_vaddr}, 64'd0);
    check_eq("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_miss_ready", {63'd0, miss_ready}, 64'd1);

    // 4K walk
    mem[34'h10004] = 32'h0000_8001;
    mem[34'h2000C] = 32'h0000_50CF;
    expq.push_back(34'h10004); expq.push_back(34'h2000C);
    push_upd(1'b0, 32'h0040_3000, 1'b1, 32'h0000_50CF, 5);
    issue(32'h0040_3000, 1'b1);
    drain();

    // 4M walk, single read (A=0 in this PTE)
    mem[34'h10004] = 32'h2000_000F;
    expq.push_back(34'h10004);
`ifdef PTW_ACCESS_CHECK_EN
    push_fault(32'h0040_3000, 3);
`else
    push_upd(1'b1, 32'h0040_3000, 1'b0, 32'h2000_000F, 3);
`endif
    issue(32'h0040_3000, 1'b0);
    drain();

    // invalid L1 PTE
    mem[34'h10800] = 32'h0000_0000;
    expq.push_back(34'h10800);
    push_fault(32'h8000_1ABC, 3);
    issue(32'h8000_1ABC, 1'b0);
    drain();

    // fault vaddr is held across a following successful walk
    mem[34'h10004] = 32'h0000_8001;
    expq.push_back(34'h10004); expq.push_back(34'h2000C);
    push_upd(1'b0, 32'h0040_3000, 1'b0, 32'h0000_50CF, 5);
    issue(32'h0040_3000, 1'b0);
    drain();
    check_eq("fault_vaddr_held", {32'd0, fault_vaddr}, {32'd0, 32'h8000_1ABC});

    // misaligned superpage
    mem[34'h10004] = 32'h0000_040F;
    expq.push_back(34'h10004);
    push_fault(32'h0040_3000, 3);
    issue(32'h0040_3000, 1'b1);
    drain();

    // write-only PTE is malformed
    mem[34'h10004] = 32'h0000_0005;
    expq.push_back(34'h10004);
    push_fault(32'h0040_3000, 3);
    issue(32'h0040_3000, 1'b0);
    drain();

    // non-leaf at level 0
    mem[34'h10004] = 32'h0000_8001;
    mem[34'h2000C] = 32'h0000_8001;
    expq.push_back(34'h10004); expq.push_back(34'h2000C);
    push_fault(32'h0040_3000, 5);
    issue(32'h0040_3000, 1'b0);
    drain();

    // leaf with A=0 at level 0
    mem[34'h2000C] = 32'h0000_508F;
    expq.push_back(34'h10004); expq.push_back(34'h2000C);
`ifdef PTW_ACCESS_CHECK_EN
    push_fault(32'h0040_3000, 5);
`else
    push_upd(1'b0, 32'h0040_3000, 1'b1, 32'h0000_508F, 5);
`endif
    issue(32'h0040_3000, 1'b1);
    drain();

    // request backpressure: three cycles of ready low
    mem[34'h2000C] = 32'h0000_50CF;
    expq.push_back(34'h10004); expq.push_back(34'h2000C);
    push_upd(1'b0, 32'h0040_3000, 1'b1, 32'h0000_50CF, 0);
    stall = 3;
    issue(32'h0040_3000, 1'b1);
    drain();

    // flush in L1_WAIT with a response arriving two cycles late
    mem[34'h10004] = 32'h0000_00CF;
    expq.push_back(34'h10004);
    extra_delay = 2;
    issue(32'h0040_3000, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("drain_busy", {63'd0, busy}, 64'd1);
    check_eq("drain_no_req", {63'd0, mem_req_valid}, 64'd0);
    drain();
    expq.push_back(34'h10004);
    push_upd(1'b1, 32'h0040_3000, 1'b0, 32'h0000_00CF, 3);
    issue(32'h0040_3000, 1'b0);
    drain();

    // flush in IDLE blocks acceptance
    flush = 1'b1;
    miss_valid = 1'b1;
    #1;
    check_eq("flush_miss_ready", {63'd0, miss_ready}, 64'd0);
    tick();
    miss_valid = 1'b0;
    flush = 1'b0;
    check_eq("flush_idle_busy", {63'd0, busy}, 64'd0);
    check_eq("flush_idle_req", {63'd0, mem_req_valid}, 64'd0);

    // flush in L1_REQ drops the unissued request
    stall = 5;
    issue(32'h0040_3000, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    stall = 0;
    check_eq("flush_req_busy", {63'd0, busy}, 64'd0);
    check_eq("flush_req_valid", {63'd0, mem_req_valid}, 64'd0);
    drain();

    // reset mid-walk
    stall = 5;
    issue(32'h0040_3000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall = 0;
    check_eq("midrst_busy", {63'd0, busy}, 64'd0);
    check_eq("midrst_req", {63'd0, mem_req_valid}, 64'd0);
    check_eq("midrst_fault_vaddr", {32'd0, fault_vaddr}, 64'd0);
    check_eq("midrst_miss_ready", {63'd0, miss_ready}, 64'd1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
